data_memory: RTL and testbench

Byte-addressable RV32IM data memory: the responder on the CPU's MEM_READ/MEM_WRITE/BUSYWAIT load-store interface. It accepts one access at a time, stalls the CPU through BUSYWAIT for a fixed, parameterised latency, and performs RV32 byte, halfword and word loads and stores selected by FUNC3, with sign or zero extension on loads. It replaces the testbench-driven READ_DATA/BUSYWAIT stimulus at the CPU's memory port.

---
 rtl/data_memory.sv | 103 ++++++++++
 tb/tb_data_memory.sv | 134 +++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: byte-addressable RV32 load/store memory with fixed-latency BUSYWAIT handshake.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses and suppress their effects.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [AW+1:0] r_addr;
    logic [2:0]    r_func3;
    logic [31:0]   r_wdata, r_rdata;
    logic          r_store;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic          w_req, w_start, w_fire, w_mis, w_we, w_unused;
    logic          w_ld_b, w_ld_h, w_sb, w_sh, w_sw;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [4:0]    w_shamt;
    logic [31:0]   w_word, w_load, w_mask, w_new;
    assign w_unused = &{1'b0, MEM_ADDRESS[31:AW+2]};
    assign w_req    = MEM_READ | MEM_WRITE;
    assign w_start  = r_state == IDLE && w_req;
    assign w_fire   = r_state == BUSY && r_cnt == '0;
    assign BUSYWAIT = RESET & (w_start | r_state == BUSY);
    assign READ_DATA = r_rdata;
    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? (w_req ? BUSY : IDLE) :
                 r_state == BUSY ? (r_cnt == '0 ? DONE : BUSY) : IDLE;
    end
    assign w_ld_b = r_func3 == 3'b000 || r_func3 == 3'b100;
    assign w_ld_h = r_func3 == 3'b001 || r_func3 == 3'b101;
    assign w_sb   = r_func3 == 3'b000;
    assign w_sh   = r_func3 == 3'b001;
    assign w_sw   = r_func3 == 3'b010;
    assign w_word = r_mem[r_addr[AW+1:2]];
    assign w_byte = r_addr[0] ? (r_addr[1] ? w_word[31:24] : w_word[15:8])
                              : (r_addr[1] ? w_word[23:16] : w_word[7:0]);
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
    // FUNC3[2] marks the unsigned load variants
    assign w_load = w_ld_b ? {{24{~r_func3[2] & w_byte[7]}}, w_byte} :
                    w_ld_h ? {{16{~r_func3[2] & w_half[15]}}, w_half} : w_word;
    assign w_shamt = w_sb ? {r_addr[1:0], 3'b000} : w_sh ? {r_addr[1], 4'b0000} : 5'd0;
    assign w_mask  = w_sb ? (32'hFF << w_shamt) : w_sh ? (32'hFFFF << w_shamt) :
                     w_sw ? 32'hFFFF_FFFF : 32'h0;
    assign w_new   = (w_word & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
    assign w_we    = w_fire & r_store & ~w_mis;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic w_ld_w, r_mis;
    assign w_ld_w = !w_ld_b && !w_ld_h;
    assign w_mis  = r_store ? ((w_sh & r_addr[0]) | (w_sw & |r_addr[1:0]))
                            : ((w_ld_h & r_addr[0]) | (w_ld_w & |r_addr[1:0]));
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_mis <= 1'b0;
        else        r_mis <= w_fire & w_mis;
    end
    assign MISALIGNED = r_mis;
`else
    assign w_mis      = 1'b0;
    assign MISALIGNED = 1'b0;
`endif
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_func3 <= '0;
            r_wdata <= '0;
            r_store <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt   <= CW'(LATENCY - 1);
                r_addr  <= MEM_ADDRESS[AW+1:0];
                r_func3 <= FUNC3;
                r_wdata <= MEM_WRITE_DATA;
                r_store <= MEM_WRITE;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_fire && !r_store) r_rdata <= w_mis ? 32'h0 : w_load;
        end
    end
    // contents survive reset; an aborted access never reaches w_fire
    always_ff @(posedge CLK) begin
        if (w_we) r_mem[r_addr[AW+1:2]] <= w_new;
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: table-driven load/store checks with a READ_DATA scoreboard queue.
module tb_data_memory;
    localparam int LAT = 4;
    logic        CLK = 1'b0, RESET = 1'b0, MEM_READ = 1'b0, MEM_WRITE = 1'b0;
    logic [2:0]  FUNC3 = '0;
    logic [31:0] MEM_ADDRESS = '0, MEM_WRITE_DATA = '0;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT, MISALIGNED;
    int          pass = 0, total = 0;
    logic [31:0] last = 32'h0;
    logic [31:0] exp_q[$];
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    data_memory #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNC3(FUNC3), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Loads update the model's last READ_DATA; stores (and both-high) leave it as is.
    task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_ld,
                          input logic exp_mis);
        int n;
        @(negedge CLK);
        MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; MEM_ADDRESS = a; MEM_WRITE_DATA = d;
        if (!wr) last = exp_ld;
        exp_q.push_back(last);
        n = 0;
        forever begin
            #1;
            if (!BUSYWAIT || n > 4 * LAT + 8) break;
            n++;
            @(negedge CLK);
        end
        chk({nm, " busy cycles"}, n, LAT + 1);
        chk({nm, " read_data"}, READ_DATA, exp_q.pop_front());
        chk({nm, " misaligned"}, {31'b0, MISALIGNED}, {31'b0, exp_mis});
        MEM_READ = 0; MEM_WRITE = 0;
        if (exp_mis) begin
            @(negedge CLK); #1;
            chk({nm, " misaligned one cycle"}, {31'b0, MISALIGNED}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF});
        tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h20,  32'h80F17F01, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h23,  32'h0,        32'hFFFFFF80});
        tbl.push_back('{1'b1, 1'b0, 3'b100, 32'h23,  32'h0,        32'h00000080});
        tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h22,  32'h0,        32'hFFFF80F1});
        tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h20,  32'h0,        32'h00007F01});
        tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h21,  32'h0,        32'h0000007F});
        tbl.push_back('{1'b1, 1'b0, 3'b100, 32'h20,  32'h0,        32'h00000001});
        tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h30,  32'h11223344, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 3'b000, 32'h31,  32'hFFFFFFAA, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h30,  32'h0,        32'h1122AA44});
        tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h32,  32'h1234BEEF, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h30,  32'h0,        32'hBEEFAA44});
        tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h0,   32'h0,        32'h12345678});
        tbl.push_back('{1'b0, 1'b1, 3'b011, 32'h10,  32'h0,        32'h0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF});
        tbl.push_back('{1'b1, 1'b0, 3'b111, 32'h10,  32'h0,        32'hDEADBEEF});
        tbl.push_back('{1'b1, 1'b1, 3'b010, 32'h60,  32'h5555AAAA, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h60,  32'h0,        32'h5555AAAA});
        tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h62,  32'h0,        32'h00005555});
        tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h60,  32'h0,        32'hFFFFAAAA});

        MEM_READ = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset busywait", {31'b0, BUSYWAIT}, 32'h0);
        chk("reset read_data", READ_DATA, 32'h0);
        chk("reset misaligned", {31'b0, MISALIGNED}, 32'h0);
        MEM_READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3,
                   tbl[i].addr, tbl[i].data, tbl[i].exp, 1'b0);

        access("rst prep store", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0);
        access("rst prep load", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge CLK);
        MEM_WRITE = 1'b1; FUNC3 = 3'b010; MEM_ADDRESS = 32'h40; MEM_WRITE_DATA = 32'hCAFEF00D;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("midreset busywait", {31'b0, BUSYWAIT}, 32'h0);
        chk("midreset read_data", READ_DATA, 32'h0);
        MEM_WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        access("after reset load", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0);

        access("mis base", 1'b0, 1'b1, 3'b010, 32'h50, 32'h01020304, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
        access("mis store", 1'b0, 1'b1, 3'b010, 32'h52, 32'hFFFFFFFF, 32'h0, 1'b1);
        access("mis check", 1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'h01020304, 1'b0);
        access("mis load", 1'b1, 1'b0, 3'b010, 32'h52, 32'h0, 32'h0, 1'b1);
`else
        access("mis store", 1'b0, 1'b1, 3'b010, 32'h52, 32'hFFFFFFFF, 32'h0, 1'b0);
        access("mis check", 1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'hFFFFFFFF, 1'b0);
        access("mis half", 1'b1, 1'b0, 3'b101, 32'h53, 32'h0, 32'h0000FFFF, 1'b0);
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
